// File: rtl/aes_pkg.sv
// Shared AES-128 sequencing types and sizes used by the round controller
// and by any swappable datapath / key-store variants.
package aes_pkg;

  localparam int AES_NR      = 10;
  localparam int AES_BLOCK_W = 128;
  localparam int KEY_IDX_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_FINAL = 2'd2,
    ST_DONE  = 2'd3
  } aes_state_e;

endpackage

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 round sequencer: owns the cipher state register and steps
// it through the external round datapath, one round per clock.
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int NR = AES_NR
) (
  input  logic                   pi_clk,
  input  logic                   pi_rst,
  input  logic                   pi_in_valid,
  output logic                   po_in_ready,
  input  logic [AES_BLOCK_W-1:0] pi_data,
  output logic [AES_BLOCK_W-1:0] po_state,
  output logic                   po_skip_mix,
  output logic [KEY_IDX_W-1:0]   po_key_idx,
  input  logic [AES_BLOCK_W-1:0] pi_round_key,
  input  logic [AES_BLOCK_W-1:0] pi_round_out,
  output logic                   po_out_valid,
  input  logic                   pi_out_ready,
  output logic [AES_BLOCK_W-1:0] po_data,
  output logic                   po_busy
);

  aes_state_e             r_fsm, w_fsm_nxt;
  logic [KEY_IDX_W-1:0]   r_rnd, w_rnd_nxt;
  logic [AES_BLOCK_W-1:0] r_state, w_state_nxt;
  logic                   w_load;

  always_ff @(posedge pi_clk or negedge pi_rst) begin
    if (!pi_rst) begin
      r_fsm   <= ST_IDLE;
      r_rnd   <= '0;
      r_state <= '0;
    end else begin
      r_fsm   <= w_fsm_nxt;
      r_rnd   <= w_rnd_nxt;
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_fsm_nxt    = r_fsm;
    w_rnd_nxt    = r_rnd;
    w_state_nxt  = r_state;
    w_load       = 1'b0;
    po_in_ready  = 1'b0;
    po_out_valid = 1'b0;
    po_busy      = 1'b0;
    po_skip_mix  = 1'b0;
    po_key_idx   = '0;

    case (r_fsm)
      ST_IDLE: begin
        po_in_ready = 1'b1;
        w_load      = pi_in_valid;
      end
      ST_ROUND: begin
        po_busy     = 1'b1;
        po_key_idx  = r_rnd;
        w_state_nxt = pi_round_out;
        w_rnd_nxt   = r_rnd + 1'b1;
        if (r_rnd == KEY_IDX_W'(NR - 1)) w_fsm_nxt = ST_FINAL;
      end
      ST_FINAL: begin
        po_busy     = 1'b1;
        po_skip_mix = 1'b1;
        po_key_idx  = KEY_IDX_W'(NR);
        w_state_nxt = pi_round_out;
        w_fsm_nxt   = ST_DONE;
      end
      ST_DONE: begin
        // Key index stays 0 so a back-to-back load sees the whitening key.
        po_out_valid = 1'b1;
        po_in_ready  = pi_out_ready;
        if (pi_out_ready) begin
          if (pi_in_valid) begin
            w_load = 1'b1;
          end else begin
            w_fsm_nxt = ST_IDLE;
            w_rnd_nxt = '0;
          end
        end
      end
      default: w_fsm_nxt = ST_IDLE;
    endcase

    if (w_load) begin
      w_state_nxt = pi_data ^ pi_round_key;
      w_rnd_nxt   = KEY_IDX_W'(1);
      w_fsm_nxt   = ST_ROUND;
    end
  end

  assign po_state = r_state;
  assign po_data  = r_state;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: provides a reference AES round datapath and key
// store, and checks every cycle against a block-level behavioural model.
module tb_aes_round_ctrl;

  logic         pi_clk = 1'b0;
  logic         pi_rst = 1'b0;
  logic         pi_in_valid = 1'b0;
  logic         po_in_ready;
  logic [127:0] pi_data = '0;
  logic [127:0] po_state;
  logic         po_skip_mix;
  logic [3:0]   po_key_idx;
  logic [127:0] pi_round_key = '0;
  logic [127:0] pi_round_out = '0;
  logic         po_out_valid;
  logic         pi_out_ready = 1'b0;
  logic [127:0] po_data;
  logic         po_busy;

  aes_round_ctrl dut (
    .pi_clk(pi_clk), .pi_rst(pi_rst),
    .pi_in_valid(pi_in_valid), .po_in_ready(po_in_ready), .pi_data(pi_data),
    .po_state(po_state), .po_skip_mix(po_skip_mix), .po_key_idx(po_key_idx),
    .pi_round_key(pi_round_key), .pi_round_out(pi_round_out),
    .po_out_valid(po_out_valid), .pi_out_ready(pi_out_ready),
    .po_data(po_data), .po_busy(po_busy)
  );

  always #5 pi_clk = ~pi_clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
  endtask

  // ---------------- AES reference pieces ----------------
  logic [7:0]   sbox [256];
  logic [127:0] rk [11];
  logic         dp_kick = 1'b0;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] a);
    return gmul(a, 8'h02);
  endfunction

  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [7:0]   b [16];
    logic [127:0] o = '0;
    for (int i = 0; i < 16; i++) b[i] = sbox[s[127-8*i -: 8]];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = b[4*((c+r)%4)+r];
    return o;
  endfunction

  function automatic logic [127:0] mix(input logic [127:0] s);
    logic [127:0] o = '0;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-8*(4*c)   -: 8];
      a1 = s[127-8*(4*c+1) -: 8];
      a2 = s[127-8*(4*c+2) -: 8];
      a3 = s[127-8*(4*c+3) -: 8];
      o[127-8*(4*c)   -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
      o[127-8*(4*c+1) -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
      o[127-8*(4*c+2) -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
      o[127-8*(4*c+3) -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
    end
    return o;
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic skip);
    logic [127:0] t = sub_shift(s);
    if (!skip) t = mix(t);
    return t ^ k;
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] pt);
    logic [127:0] s = pt ^ rk[0];
    for (int r = 1; r < 10; r++) s = aes_round(s, rk[r], 1'b0);
    return aes_round(s, rk[10], 1'b1);
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, b;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      b = inv;
      sbox[x] = b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    end
  endtask

  task automatic load_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rcon, 24'h0};
        rcon = xt(rcon);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int k = 0; k < 11; k++) rk[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
    dp_kick = ~dp_kick;
  endtask

  // External round datapath and key store, driven from DUT outputs.
  always @(po_state, po_key_idx, po_skip_mix, dp_kick) begin
    pi_round_key = (po_key_idx <= 4'd10) ? rk[po_key_idx] : 128'h0;
    pi_round_out = aes_round(po_state, pi_round_key, po_skip_mix);
  end

  // ---------------- Block-level behavioural model ----------------
  // m_cnt: 0 idle, 1..10 edges into the block (round-key index), 11 result held.
  int           m_cnt = 0;
  int           m_acc = 0;
  int           m_acc_n = 0;
  int           cyc = 0;
  logic [127:0] m_res = '0;
  logic [127:0] m_last = '0;

  always @(posedge pi_clk) cyc <= cyc + 1;

  always @(posedge pi_clk or negedge pi_rst) begin
    if (!pi_rst) begin
      m_cnt  <= 0;
      m_res  <= '0;
      m_last <= '0;
    end else begin
      if ((m_cnt == 0 || (m_cnt == 11 && pi_out_ready)) && pi_in_valid) begin
        m_cnt   <= 1;
        m_res   <= aes_enc(pi_data);
        m_acc   <= m_acc + 1;
        m_acc_n <= cyc;
      end else if (m_cnt >= 1 && m_cnt <= 10) begin
        m_cnt <= m_cnt + 1;
      end else if (m_cnt == 11 && pi_out_ready) begin
        m_cnt  <= 0;
        m_last <= m_res;
      end
    end
  end

  logic prev_vld = 1'b0;

  always @(negedge pi_clk) begin
    logic busy_e;
    busy_e = (m_cnt >= 1 && m_cnt <= 10);
    chk("busy", 128'(po_busy), 128'(busy_e));
    chk("out_valid", 128'(po_out_valid), 128'(m_cnt == 11));
    chk("in_ready", 128'(po_in_ready), 128'(m_cnt == 0 || (m_cnt == 11 && pi_out_ready)));
    chk("skip_mix", 128'(po_skip_mix), 128'(m_cnt == 10));
    chk("key_idx", 128'(po_key_idx), busy_e ? 128'(m_cnt) : 128'(0));
    if (m_cnt == 0)  chk("idle_data", po_data, m_last);
    if (m_cnt == 11) chk("ciphertext", po_data, m_res);
    if (pi_rst && po_out_valid && !prev_vld)
      chk("latency", 128'(cyc - m_acc_n), 128'(11));
    prev_vld = pi_rst && po_out_valid;
  end

  // ---------------- Stimulus ----------------
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  task automatic step();
    @(posedge pi_clk);
    #1;
  endtask

  task automatic send(input logic [127:0] d);
    int a0 = m_acc;
    bit ok = 1'b0;
    pi_data = d;
    pi_in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step();
      if (m_acc != a0) begin ok = 1'b1; break; end
    end
    if (!ok) chk("accept_timeout", 128'(0), 128'(1));
    pi_in_valid = 1'b0;
  endtask

  task automatic wait_done();
    bit ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (po_out_valid) begin ok = 1'b1; break; end
      step();
    end
    if (!ok) chk("done_timeout", 128'(0), 128'(1));
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    int acc_a, acc_b, target, pend;
    build_sbox();
    load_key(FIPS_KEY);
    chk("model_fips", aes_enc(FIPS_PT), FIPS_CT);
    chk("model_sbox", 128'({sbox[8'h00], sbox[8'h53]}), 128'(16'h63ed));

    repeat (3) step();
    chk("rst_data", po_data, 128'h0);
    chk("rst_in_ready", 128'(po_in_ready), 128'(1));
    pi_rst = 1'b1;
    step();

    // FIPS vector, with junk on the input while busy, then a long stall.
    send(FIPS_PT);
    for (int i = 0; i < 6; i++) begin
      pi_in_valid = 1'($urandom % 2);
      pi_data = rnd128();
      step();
    end
    pi_in_valid = 1'b0;
    wait_done();
    chk("fips_ct", po_data, FIPS_CT);
    pi_in_valid = 1'b1;
    pi_data = rnd128();
    repeat (20) step();
    chk("stall_data", po_data, FIPS_CT);
    chk("stall_no_accept", 128'(m_acc), 128'(1));
    pi_in_valid = 1'b0;
    pi_out_ready = 1'b1;
    step();
    pi_out_ready = 1'b0;
    step();

    // Back-to-back blocks with both handshakes held high.
    pi_out_ready = 1'b1;
    send(rnd128());
    acc_a = m_acc_n;
    send(rnd128());
    acc_b = m_acc_n;
    chk("b2b_gap", 128'(acc_b - acc_a), 128'(11));
    send(rnd128());
    wait_done();
    repeat (2) step();
    pi_out_ready = 1'b0;

    // Reset during round 5, then a full block afterwards.
    send(rnd128());
    repeat (4) step();
    pi_rst = 1'b0;
    #1;
    chk("mid_rst_busy", 128'(po_busy), 128'(0));
    chk("mid_rst_valid", 128'(po_out_valid), 128'(0));
    chk("mid_rst_data", po_data, 128'h0);
    chk("mid_rst_idx", 128'(po_key_idx), 128'(0));
    chk("mid_rst_in_ready", 128'(po_in_ready), 128'(1));
    repeat (2) step();
    pi_rst = 1'b1;
    step();
    send(FIPS_PT);
    wait_done();
    chk("post_rst_fips", po_data, FIPS_CT);
    pi_out_ready = 1'b1;
    step();
    pi_out_ready = 1'b0;

    // New key while idle, then randomized handshakes and data.
    load_key(rnd128());
    target = m_acc + 25;
    pend = 0;
    for (int c = 0; c < 3000 && m_acc < target; c++) begin
      pi_out_ready = ($urandom % 3) != 0;
      if (pend == 0 && ($urandom % 3) == 0) begin
        pend = m_acc + 1;
        pi_data = rnd128();
        pi_in_valid = 1'b1;
      end
      step();
      if (pend != 0 && m_acc >= pend) begin
        pend = 0;
        pi_in_valid = 1'b0;
      end
    end
    chk("random_blocks", 128'(m_acc >= target), 128'(1));
    pi_in_valid = 1'b0;
    pi_out_ready = 1'b1;
    repeat (15) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/aes_round_ctrl.md
# aes_round_ctrl

Iterative AES-128 encryption round sequencer. Accepts a plaintext block over a valid/ready handshake, owns the 128-bit cipher state register, and steps it through the initial AddRoundKey plus rounds 1–10. Each round goes through the shared combinational round datapath: sub bytes → shift rows → optional mix columns → add round key. It selects the round-key index and mix-columns bypass, then returns the ciphertext over a second valid/ready handshake. It sits between the block-level I/O and the round datapath and the external round-key store.

## Interface
- NR, 10, number of AES rounds; fixed for AES-128.
- pi_clk  input  1  rising-edge clock
- pi_rst  input  1  asynchronous, active-low reset
- pi_in_valid  input  1  plaintext present on pi_data
- po_in_ready  output  1  block accepts pi_data this cycle
- pi_data  input  128  plaintext; MSB is byte 0 of the state matrix
- po_state  output  128  current state register, feeds the round datapath
- po_skip_mix  output  1  1 = datapath bypasses mix columns (final round)
- po_key_idx  output  4  round-key index 0..10 requested from the key store
- pi_round_key  input  128  round key for po_key_idx, combinational same cycle
- pi_round_out  input  128  round datapath result for po_state / po_key_idx
- po_out_valid  output  1  ciphertext valid on po_data
- pi_out_ready  input  1  consumer takes po_data this cycle
- po_data  output  128  ciphertext (equals po_state in DONE)
- po_busy  output  1  high in ROUND and FINAL

## Operation
- FSM states: IDLE, ROUND, FINAL, DONE. 4-bit round counter rnd.
- IDLE:
  - po_in_ready=1, po_key_idx=0.
  - On pi_in_valid: state ← pi_data ^ pi_round_key (initial AddRoundKey), rnd ← 1, go to ROUND.
- ROUND:
  - po_key_idx=rnd, po_skip_mix=0, state ← pi_round_out, rnd ← rnd+1.
  - When rnd==NR-1 (9) on the update cycle, go to FINAL.
- FINAL:
  - po_key_idx=NR, po_skip_mix=1, state ← pi_round_out, go to DONE.
- DONE:
  - po_out_valid=1, po_data=state, held stable until pi_out_ready.
  - po_in_ready = pi_out_ready, so a back-to-back transfer is possible.
  - On pi_out_ready with pi_in_valid: load the new block exactly as in IDLE and go to ROUND.
  - On pi_out_ready without pi_in_valid: go to IDLE.
- po_skip_mix is 0 in every state except FINAL. po_key_idx never exceeds 10.
- pi_in_valid is ignored in ROUND and FINAL, where po_in_ready=0; upstream must hold the data.
- The state register updates only on the transitions listed. It is otherwise stable, including while DONE is stalled.
- Width rules:
  - rnd is 4 bits and never wraps.
  - po_key_idx is driven from the FSM as 0 in IDLE/DONE-load, rnd in ROUND, and 10 in FINAL.

## Timing
- Reset (pi_rst=0, asynchronous):
  - State is IDLE, rnd=0, state register=0.
  - po_in_ready=1, po_out_valid=0, po_busy=0, po_skip_mix=0, po_key_idx=0, po_data=0.
  - Reset asserted mid-operation discards the block with no output.
- Latency:
  - Acceptance edge T.
  - ROUND edges T+1..T+9.
  - FINAL edge T+10.
  - po_out_valid high from the cycle after T+10, i.e. 11 cycles from acceptance.
- Throughput: one block per 11 cycles with pi_out_ready held high and back-to-back input.
- All outputs are registered or decoded from registered state only. There is no combinational path from pi_* to po_*, except po_in_ready from pi_out_ready in DONE.

## Structure
- Shared package aes_pkg:
  - FSM state enum.
  - AES_NR=10, AES_BLOCK_W=128, KEY_IDX_W=4.
- The FSM and the state register live in one module.
- No sub-module is needed. The round datapath and key store stay external, so they can be swapped for an encrypt/decrypt variant.

## Test plan
- FIPS-197 C.1 vector:
  - Stimulus: key store loaded from 000102030405060708090a0b0c0d0e0f; pi_data=00112233445566778899aabbccddeeff; reference round datapath.
  - Response: po_data=69c4e0d86a7b0430d8cdb78070b4c55a, po_out_valid exactly 11 cycles after acceptance.
- Key index trace: log po_key_idx/po_skip_mix on one block → sequence 0,1..9,10; skip_mix=1 only with idx 10.
- Output stall: hold pi_out_ready=0 for 20 cycles in DONE → po_data unchanged, po_in_ready=0, no new block accepted.
- Back-to-back: two blocks, pi_in_valid and pi_out_ready held high → second block accepted on the same edge the first leaves; outputs 11 cycles apart, both correct.
- Reset mid-round: assert pi_rst=0 during round 5 → all outputs at reset values immediately; next block after release encrypts correctly with full 11-cycle latency.
- Input during busy: toggle pi_in_valid with different data during ROUND → ignored; po_in_ready=0; the in-flight result is unaffected.
